gray_decoder: RTL and testbench
===============================

GRAY_DECODER -- requirements
Module: gray_decoder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the Gray/binary word width; legal WIDTH >= 4.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port gray_in  input  WIDTH  Gray-coded word offered by the sender.
REQ-005 The block SHALL have port in_valid  input  1  gray_in is valid this cycle.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-007 The block SHALL have port bin_out  output  WIDTH  last decoded binary word, held until the next result.
REQ-008 The block SHALL have port out_valid  output  1  single-cycle pulse marking a new bin_out.
REQ-009 The block SHALL have port seq_error  output  1  qualified by out_valid; accepted word is not a single-step Gray transition.
REQ-010 The block SHALL have port seg_out  output  7  active-low 7-segment hex digit of bin_out[3:0], bit order {g,f,e,d,c,b,a}.

Function
REQ-011 The FSM SHALL have states IDLE, DECODE and DONE; in_ready = 1 only in IDLE.
REQ-012 A handshake SHALL occur on a rising edge where in_valid && in_ready; gray_in is captured and the state moves IDLE->DECODE.
REQ-013 in_valid outside IDLE SHALL be ignored, with no capture and no side effect.
REQ-014 DECODE SHALL resolve one bit per edge, MSB first: bin[WIDTH-1] = g[WIDTH-1], then bin[i] = bin[i+1] ^ g[i], taking exactly WIDTH edges.
REQ-015 After the last bit, DECODE SHALL move to DONE, and DONE SHALL move to IDLE on the next edge.
REQ-016 out_valid SHALL be high exactly in the DONE cycle, i.e. WIDTH edges after the accepting edge; throughput is one word per WIDTH+2 cycles.
REQ-017 bin_out and seg_out SHALL update on the edge entering DONE and hold otherwise; bin_out SHALL never show partial results.
REQ-018 seq_error SHALL be 1 in DONE iff a previous word was accepted since reset and popcount(current_gray ^ previous_gray) != 1; this includes a repeated word (distance 0).
REQ-019 The first word after reset SHALL report seq_error = 0.
REQ-020 The previous-word register SHALL update to the current word on the edge entering DONE, regardless of error.
REQ-021 The seg_out encoding for 0..F SHALL be 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
REQ-022 seq_error SHALL be 0 whenever out_valid = 0.

Reset
REQ-023 While rst = 1, the block SHALL hold state IDLE, bin_out = 0, out_valid = 0, seq_error = 0, seg_out = 1111111 (blank), and in_ready = 1 once rst deasserts.
REQ-024 Reset during DECODE or DONE SHALL abort the operation with no out_valid pulse.
REQ-025 Reset SHALL clear the "previous word seen" flag, so the next word is unchecked.

Structure
REQ-026 A shared package SHALL hold the state enum and the 16-entry active-low hex segment constant table.
REQ-027 The 7-segment lookup SHALL be one combinational sub-module, hex_to_seg7 (4-bit in, 7-bit out), reused by the display path.
REQ-028 The popcount/distance check SHALL be local combinational logic inside gray_decoder.

Verification (WIDTH = 4)
REQ-029 Reset scenario: assert rst mid-run -> bin_out = 0000, seg_out = 1111111, out_valid = 0, in_ready = 1 after release.
REQ-030 First-word scenario: gray 0110 -> 4 edges later out_valid pulse, bin_out = 0100, seg_out = 0011001, seq_error = 0.
REQ-031 Single-step scenario: then gray 0111 -> bin_out = 0101, seg_out = 0010010, seq_error = 0.
REQ-032 Non-single-step scenario: then gray 0100 (distance 2) -> bin_out = 0111, seg_out = 1111000, seq_error = 1; then gray 0100 again -> seq_error = 1.
REQ-033 Ignored-input scenario: in_valid with gray 1000 held during DECODE -> in_ready = 0, word not captured; once offered in IDLE -> bin_out = 1111, seg_out = 0001110.
REQ-034 Reset-mid-decode scenario: rst asserted 2 edges after accept -> no out_valid; next word 0011 -> bin_out = 0010, seq_error = 0.

Source files
------------

// File: rtl/gray_decoder_pkg.sv
// Shared types and constants for the serial Gray-to-binary decoder
// and its hex seven-segment display path.
package gray_decoder_pkg;

    localparam int unsigned HEX_W = 4;
    localparam int unsigned SEG_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to active-low seven-segment pattern.
module hex_to_seg7
    import gray_decoder_pkg::*;
(
    input  logic [HEX_W-1:0] i_hex,
    output logic [SEG_W-1:0] o_seg_c
);

    assign o_seg_c = SEG_TABLE[i_hex];

endmodule

// File: rtl/gray_decoder.sv
// Bit-serial Gray-to-binary decoder (MSB first, one bit per clock) with
// single-step sequence checking and a hex display of the low nibble.
module gray_decoder
    import gray_decoder_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             out_valid,
    output logic             seq_error,
    output logic [6:0]       seg_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned POP_W = $clog2(WIDTH + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_finish;

    logic [WIDTH-1:0]   r_gray;
    logic [WIDTH-1:0]   r_gsh;
    logic [WIDTH-2:0]   r_work;
    logic               r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_prev;
    logic               r_prev_valid;

    logic               w_bit;
    logic [WIDTH-1:0]   w_work_next;
    logic [WIDTH-1:0]   w_diff;
    logic [POP_W-1:0]   w_dist;
    logic               w_step_err;
    logic [SEG_W-1:0]   w_seg;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control strobes
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (r_cnt == '0) begin
                    w_finish     = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Each binary bit is the running XOR of the Gray bits seen so far
    assign w_bit       = r_acc ^ r_gsh[WIDTH-1];
    assign w_work_next = {r_work, w_bit};

    // Hamming distance between the current and previously completed word
    assign w_diff = r_gray ^ r_prev;

    always_comb begin
        w_dist = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_dist = w_dist + POP_W'(w_diff[i]);
        end
    end

    assign w_step_err = r_prev_valid && (w_dist != POP_W'(1));

    hex_to_seg7 u_hex_to_seg7 (
        .i_hex   (w_work_next[HEX_W-1:0]),
        .o_seg_c (w_seg)
    );

    // Serial decode datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gray <= '0;
            r_gsh  <= '0;
            r_work <= '0;
            r_acc  <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_gray <= gray_in;
            r_gsh  <= gray_in;
            r_work <= '0;
            r_acc  <= 1'b0;
            r_cnt  <= CNT_W'(WIDTH - 1);
        end else if (r_state == ST_DECODE) begin
            r_gsh  <= r_gsh << 1;
            r_work <= w_work_next[WIDTH-2:0];
            r_acc  <= w_bit;
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

    // Result, display and history registers; only the DONE entry edge writes them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_out      <= '0;
            seg_out      <= SEG_BLANK;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (w_finish) begin
            bin_out      <= w_work_next;
            seg_out      <= w_seg;
            r_prev       <= r_gray;
            r_prev_valid <= 1'b1;
        end
    end

    // Handshake and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            seq_error <= 1'b0;
        end else begin
            in_ready  <= (w_state_next == ST_IDLE);
            out_valid <= w_finish;
            seq_error <= w_finish && w_step_err;
        end
    end

endmodule

// File: tb/tb_gray_decoder.sv
// Scoreboard bench for gray_decoder: directed scenarios followed by
// randomized traffic with occasional mid-decode resets.
module tb_gray_decoder;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] gray_in = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] bin_out;
    logic             out_valid;
    logic             seq_error;
    logic [6:0]       seg_out;

    gray_decoder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .gray_in   (gray_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_out   (bin_out),
        .out_valid (out_valid),
        .seq_error (seq_error),
        .seg_out   (seg_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] gray;
        logic [WIDTH-1:0] bin;
        logic [6:0]       seg;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [6:0] seg_ref [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Binary value whose Gray code b ^ (b >> 1) equals g, found by search
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        for (int v = 0; v < (1 << WIDTH); v++) begin
            b = WIDTH'(v);
            if ((b ^ (b >> 1)) == g) return b;
        end
        return '0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: models busy window, pops expected results, tracks held outputs
    initial begin
        int               busy;
        bit               prev_valid;
        logic [WIDTH-1:0] prev;
        logic [WIDTH-1:0] last_bin;
        logic [6:0]       last_seg;
        exp_t             e;
        bit               exp_err;
        busy = 0; prev_valid = 0; prev = '0; last_bin = '0; last_seg = 7'h7f;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_bin_out", 32'(bin_out), 32'h0);
                check("rst_seg_out", 32'(seg_out), 32'h7f);
                check("rst_out_valid", 32'(out_valid), 32'h0);
                check("rst_seq_error", 32'(seq_error), 32'h0);
                busy = 0; prev_valid = 0; last_bin = '0; last_seg = 7'h7f;
                q.delete();
            end else begin
                check("in_ready", 32'(in_ready), 32'(busy == 0));
                check("out_valid", 32'(out_valid), 32'(busy == 1));
                if (busy == 1) begin
                    if (q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL scoreboard_empty: got result with no expected entry at %0t", $time);
                    end else begin
                        e = q.pop_front();
                        exp_err = prev_valid && ($countones(e.gray ^ prev) != 1);
                        check("bin_out", 32'(bin_out), 32'(e.bin));
                        check("seg_out", 32'(seg_out), 32'(e.seg));
                        check("seq_error", 32'(seq_error), 32'(exp_err));
                        prev = e.gray; prev_valid = 1;
                        last_bin = e.bin; last_seg = e.seg;
                    end
                end else begin
                    check("seq_error_idle", 32'(seq_error), 32'h0);
                    check("bin_out_hold", 32'(bin_out), 32'(last_bin));
                    check("seg_out_hold", 32'(seg_out), 32'(last_seg));
                end
                if (busy > 0) busy--;
                else if (in_valid) busy = WIDTH + 1;
            end
        end
    end

    task automatic do_reset(input int cycles);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Offer a word until accepted; returns 1 ns after the accepting edge
    task automatic send(input logic [WIDTH-1:0] g);
        exp_t e;
        bit   ok;
        e.gray = g;
        e.bin  = gray_to_bin(g);
        e.seg  = seg_ref[e.bin[3:0]];
        gray_in  = g;
        in_valid = 1'b1;
        ok = 0;
        for (int t = 0; t < 4 * WIDTH && !ok; t++) begin
            if (in_ready) begin
                q.push_back(e);
                ok = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        gray_in  = WIDTH'($urandom);
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL send_timeout: word %0h not accepted at %0t", g, $time);
        end
    endtask

    task automatic wait_done();
        repeat (WIDTH + 1) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] last;
        int               sel;
        do_reset(3);

        send(4'b0110); wait_done();
        check("first_bin", 32'(bin_out), 32'b0100);
        check("first_seg", 32'(seg_out), 32'b0011001);

        send(4'b0111); wait_done();
        check("step_bin", 32'(bin_out), 32'b0101);
        check("step_seg", 32'(seg_out), 32'b0010010);

        send(4'b0100); wait_done();
        check("jump_bin", 32'(bin_out), 32'b0111);
        check("jump_seg", 32'(seg_out), 32'b1111000);
        send(4'b0100); wait_done();

        send(4'b0101);
        gray_in = 4'b1000; in_valid = 1'b1;
        #1 check("busy_not_ready", 32'(in_ready), 32'h0);
        send(4'b1000); wait_done();
        check("ignored_bin", 32'(bin_out), 32'b1111);
        check("ignored_seg", 32'(seg_out), 32'b0001110);

        send(4'b0101);
        repeat (2) @(posedge clk);
        #1 do_reset(2);
        check("abort_bin", 32'(bin_out), 32'h0);
        check("abort_seg", 32'(seg_out), 32'h7f);
        repeat (WIDTH + 2) @(posedge clk);
        #1;
        send(4'b0011); wait_done();
        check("after_abort_bin", 32'(bin_out), 32'b0010);

        last = 4'b0011;
        for (int n = 0; n < 300; n++) begin
            sel = int'($urandom_range(0, 3));
            if (sel == 0) last = WIDTH'($urandom);
            else if (sel < 3) last = last ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
            send(last);
            sel = int'($urandom_range(0, 19));
            if (sel == 0) begin
                repeat ($urandom_range(0, WIDTH - 1)) @(posedge clk);
                #1 do_reset(2);
            end else if (sel < 8) begin
                wait_done();
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (WIDTH + 3) @(posedge clk);
        #1 check("drain", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
